// File: rtl/alu_accumulator_if.sv
// rtl/alu_accumulator_if.sv - control/status bundle between controller and accumulator ALU
interface alu_accumulator_if;
  logic       load_a;
  logic [7:0] b_value;
  logic [1:0] op;
  logic       start;
  logic       enable_out;
  logic [7:0] acc_value;
  logic       carry_flag;
  logic       zero_flag;
  logic       busy;
  logic       done;

  modport master (
    output load_a, b_value, op, start, enable_out,
    input  acc_value, carry_flag, zero_flag, busy, done
  );

  modport slave (
    input  load_a, b_value, op, start, enable_out,
    output acc_value, carry_flag, zero_flag, busy, done
  );
endinterface

// File: rtl/alu_accumulator.sv
// rtl/alu_accumulator.sv - accumulator with 1-cycle add/sub and 8-cycle shift-add multiply
module alu_accumulator (
  input  logic               clk,
  input  logic               reset,
  alu_accumulator_if.slave   bus,
  inout  wire  [7:0]         w_bus
);
  typedef enum logic {IDLE, MUL} state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  state_t      state;
  logic [7:0]  acc;
  logic        carry;
  logic        zero;
  logic        busy_r;
  logic        done_r;
  logic [15:0] mcand;
  logic [7:0]  mplier;
  logic [15:0] product;
  logic [2:0]  count;

  logic [8:0]  sum_add;
  logic [8:0]  sum_sub;
  logic [15:0] product_next;

  always_comb begin
    sum_add      = {1'b0, acc} + {1'b0, bus.b_value};
    sum_sub      = {1'b0, acc} + {1'b0, ~bus.b_value} + 9'd1;
    product_next = mplier[0] ? (product + mcand) : product;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      acc     <= 8'd0;
      carry   <= 1'b0;
      zero    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      mcand   <= 16'd0;
      mplier  <= 8'd0;
      product <= 16'd0;
      count   <= 3'd0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          // load_a takes priority and silently drops a simultaneous start
          if (bus.load_a) begin
            acc <= w_bus;
          end else if (bus.start) begin
            case (bus.op)
              OP_ADD: begin
                acc    <= sum_add[7:0];
                carry  <= sum_add[8];
                zero   <= (sum_add[7:0] == 8'd0);
                done_r <= 1'b1;
              end
              OP_SUB: begin
                acc    <= sum_sub[7:0];
                carry  <= sum_sub[8];
                zero   <= (sum_sub[7:0] == 8'd0);
                done_r <= 1'b1;
              end
              OP_MUL: begin
                mcand   <= {8'd0, acc};
                mplier  <= bus.b_value;
                product <= 16'd0;
                count   <= 3'd0;
                busy_r  <= 1'b1;
                state   <= MUL;
              end
              default: done_r <= 1'b1;
            endcase
          end
        end
        MUL: begin
          product <= product_next;
          mplier  <= mplier >> 1;
          mcand   <= mcand << 1;
          count   <= count + 3'd1;
          // acc stays untouched until the final iteration writes the product
          if (count == 3'd7) begin
            acc    <= product_next[7:0];
            carry  <= (product_next[15:8] != 8'd0);
            zero   <= (product_next[7:0] == 8'd0);
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign w_bus          = bus.enable_out ? acc : 8'bz;
  assign bus.acc_value  = acc;
  assign bus.carry_flag = carry;
  assign bus.zero_flag  = zero;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
endmodule

// File: tb/tb_alu_accumulator.sv
// tb/tb_alu_accumulator.sv - directed and randomized self-checking bench for alu_accumulator
module tb_alu_accumulator;
  logic       clk;
  logic       reset;
  logic       drv_en;
  logic [7:0] drv;
  wire  [7:0] w_bus;

  alu_accumulator_if ifc();

  alu_accumulator dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc),
    .w_bus (w_bus)
  );

  assign w_bus = drv_en ? drv : 8'bz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: architectural state only
  int m_acc;
  bit m_c;
  bit m_z;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_acc"},   ifc.acc_value, m_acc[7:0]);
    check({tag, "_carry"}, ifc.carry_flag, m_c);
    check({tag, "_zero"},  ifc.zero_flag, m_z);
  endtask

  task automatic do_load(input logic [7:0] v);
    drv = v;
    drv_en = 1'b1;
    ifc.load_a = 1'b1;
    tick;
    ifc.load_a = 1'b0;
    drv_en = 1'b0;
    m_acc = v;
    check_state("load");
    check("load_done", ifc.done, 1'b0);
  endtask

  task automatic do_op(input logic [1:0] opc, input logic [7:0] b, input bit junk);
    int p;
    int pre;
    ifc.op = opc;
    ifc.b_value = b;
    ifc.start = 1'b1;
    tick;
    ifc.start = 1'b0;
    if (opc != 2'b10) begin
      if (opc == 2'b00) begin
        p = m_acc + b;
        m_acc = p % 256;
        m_c = (p > 255);
        m_z = (m_acc == 0);
      end else if (opc == 2'b01) begin
        m_c = (m_acc >= b);
        m_acc = (m_acc - b + 256) % 256;
        m_z = (m_acc == 0);
      end
      check("alu_busy", ifc.busy, 1'b0);
      check("alu_done", ifc.done, 1'b1);
      check_state("alu");
      tick;
      check("alu_done_clr", ifc.done, 1'b0);
    end else begin
      pre = m_acc;
      p = m_acc * b;
      check("mul_busy_e0", ifc.busy, 1'b1);
      check("mul_done_e0", ifc.done, 1'b0);
      for (int i = 1; i < 8; i++) begin
        if (junk) begin
          ifc.b_value = 8'($urandom);
          ifc.op = 2'b00;
          ifc.start = 1'b1;
          ifc.load_a = (i == 3);
          drv = 8'($urandom);
          drv_en = 1'b1;
        end
        tick;
        check("mul_busy", ifc.busy, 1'b1);
        check("mul_acc_hold", ifc.acc_value, pre[7:0]);
        check("mul_done_early", ifc.done, 1'b0);
      end
      ifc.start = 1'b0;
      ifc.load_a = 1'b0;
      drv_en = 1'b0;
      tick;
      m_acc = p % 256;
      m_c = (p > 255);
      m_z = (m_acc == 0);
      check("mul_busy_end", ifc.busy, 1'b0);
      check("mul_done", ifc.done, 1'b1);
      check_state("mul");
      tick;
      check("mul_done_clr", ifc.done, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b0;
    drv_en = 1'b0;
    drv = 8'h00;
    ifc.load_a = 1'b0;
    ifc.b_value = 8'h00;
    ifc.op = 2'b11;
    ifc.start = 1'b0;
    ifc.enable_out = 1'b0;
    m_acc = 0; m_c = 0; m_z = 0;
    #12;
    check_state("rst");
    check("rst_busy", ifc.busy, 1'b0);
    check("rst_done", ifc.done, 1'b0);
    #11 reset = 1'b1;
    tick;

    do_load(8'h0A);

    // add with carry, then wrap to zero
    do_load(8'hF0);
    do_op(2'b00, 8'h20, 1'b0);
    do_load(8'h01);
    do_op(2'b00, 8'hFF, 1'b0);

    // subtract cases
    do_load(8'h0A);
    do_op(2'b01, 8'h03, 1'b0);
    do_load(8'h03);
    do_op(2'b01, 8'h0A, 1'b0);
    do_load(8'h55);
    do_op(2'b01, 8'h55, 1'b0);

    // no-op keeps flags and still pulses done
    do_op(2'b11, 8'h12, 1'b0);

    // multiply, then overflow to zero with junk injected while busy
    do_load(8'h0C);
    do_op(2'b10, 8'h0B, 1'b0);
    do_load(8'h20);
    do_op(2'b10, 8'h10, 1'b1);

    // load_a and start in the same cycle: only the load happens
    drv = 8'h3C;
    drv_en = 1'b1;
    ifc.load_a = 1'b1;
    ifc.start = 1'b1;
    ifc.op = 2'b00;
    ifc.b_value = 8'h01;
    tick;
    ifc.load_a = 1'b0;
    ifc.start = 1'b0;
    drv_en = 1'b0;
    m_acc = 8'h3C;
    check_state("ldst");
    check("ldst_done", ifc.done, 1'b0);
    tick;
    check("ldst_done2", ifc.done, 1'b0);
    check_state("ldst2");

    // bus drive: enabled shows acc, disabled leaves the bus to the other driver
    do_load(8'h5A);
    ifc.enable_out = 1'b1;
    #1;
    check("bus_drive", w_bus, 8'h5A);
    ifc.enable_out = 1'b0;
    drv = 8'hA5;
    drv_en = 1'b1;
    #1;
    check("bus_release", w_bus, 8'hA5);
    drv_en = 1'b0;
    do_load(8'hA5);

    // reset after four multiply iterations aborts cleanly
    do_load(8'h77);
    ifc.op = 2'b10;
    ifc.b_value = 8'h99;
    ifc.start = 1'b1;
    tick;
    ifc.start = 1'b0;
    repeat (4) tick;
    reset = 1'b0;
    #1;
    m_acc = 0; m_c = 0; m_z = 0;
    check_state("abort");
    check("abort_busy", ifc.busy, 1'b0);
    check("abort_done", ifc.done, 1'b0);
    #2 reset = 1'b1;
    repeat (6) begin
      tick;
      check("abort_no_done", ifc.done, 1'b0);
    end
    check_state("abort_hold");
    do_load(8'h21);
    do_op(2'b00, 8'h12, 1'b0);

    // randomized mix against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) do_load(8'($urandom));
      do_op(2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    ifc.enable_out = 1'b1;
    #1;
    check("bus_final", w_bus, m_acc[7:0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
